// File: rtl/ami_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ami_pkg
// Purpose  : Shared types and helpers for the AXI master write interface:
//            AXI response encoding, burst type, 4KB boundary size and the
//            response-severity merge function.
// Macros   : none
// Revision : 1.0 - initial release
// ============================================================================
package ami_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam int         BOUNDARY_4K = 4096;

    // Worst of two responses. EXOKAY is folded onto OKAY first; after that
    // the numeric encoding orders severity (DECERR > SLVERR > OKAY).
    function automatic resp_t resp_worst(input resp_t a, input resp_t b);
        resp_t fa;
        resp_t fb;
        fa = (a == EXOKAY) ? OKAY : a;
        fb = (b == EXOKAY) ? OKAY : b;
        return (fa > fb) ? fa : fb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ami_sfifo.sv
`default_nettype none
// ============================================================================
// Module   : ami_sfifo
// Purpose  : Small synchronous FIFO with first-word-fall-through read port.
// Ports    : ACLK, ARESETn     clock, asynchronous active-low reset
//            push, push_data   write side (ignored while full)
//            pop, pop_data     read side, pop_data shows the head entry
//            full, empty       occupancy flags
// Macros   : none
// Revision : 1.0 - initial release
// ============================================================================
module ami_sfifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);

    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);

    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_PW-1:0] r_wr;
    logic [c_PW-1:0] r_rd;
    logic [c_CW-1:0] r_cnt;
    logic            w_push;
    logic            w_pop;

    function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
        return (p == c_PW'(DEPTH - 1)) ? '0 : p + c_PW'(1);
    endfunction

    assign full     = (r_cnt == c_CW'(DEPTH));
    assign empty    = (r_cnt == '0);
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign pop_data = r_mem[r_rd];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= ptr_inc(r_wr);
            if (w_pop)  r_rd <= ptr_inc(r_rd);
            if (w_push && !w_pop)      r_cnt <= r_cnt + c_CW'(1);
            else if (w_pop && !w_push) r_cnt <= r_cnt - c_CW'(1);
        end
    end

    // Storage needs no reset: entries are only observed while non-empty.
    always_ff @(posedge ACLK) begin
        if (w_push) r_mem[r_wr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/ami_w_split.sv
`default_nettype none
// ============================================================================
// Module   : ami_w_split
// Purpose  : AXI master write interface. Splits user write requests into
//            legal INCR bursts (MAX_BURST beats, never crossing 4KB),
//            generates WLAST, limits outstanding bursts, keeps AW ahead of
//            W and returns user write responses.
// Ports    : ACLK/ARESETn         clock, asynchronous active-low reset
//            AW*/W*/B*            AXI write master channels
//            usr_aw*              user request (id, addr, beat count)
//            usr_w*               user write data, passed through to W
//            usr_b*               user response (usr_blast marks the end
//                                 of a request)
// Macros   : AMI_W_RESP_MERGE_EN  defined: one merged usr_b per request
//                                 (worst response of all sub-bursts);
//                                 undefined: one usr_b per AXI sub-burst.
// Revision : 1.0 - initial release
// ============================================================================
module ami_w_split
    import ami_pkg::*;
#(
    parameter int AXI_DW    = 128,
    parameter int AXI_AW    = 32,
    parameter int AXI_IW    = 8,
    parameter int AXI_LW    = 8,
    parameter int UBW       = 16,
    parameter int MAX_BURST = 256,
    parameter int AMI_OD    = 4
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    output logic [AXI_IW-1:0]   AWID,
    output logic [AXI_AW-1:0]   AWADDR,
    output logic [AXI_LW-1:0]   AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [AXI_DW-1:0]   WDATA,
    output logic [AXI_DW/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [AXI_IW-1:0]   BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,
    input  logic [AXI_IW-1:0]   usr_awid,
    input  logic [AXI_AW-1:0]   usr_awaddr,
    input  logic [UBW-1:0]      usr_awbeats,
    input  logic                usr_awvalid,
    output logic                usr_awready,
    input  logic [AXI_DW-1:0]   usr_wdata,
    input  logic [AXI_DW/8-1:0] usr_wstrb,
    input  logic                usr_wvalid,
    output logic                usr_wready,
    output logic [AXI_IW-1:0]   usr_bid,
    output logic [1:0]          usr_bresp,
    output logic                usr_blast,
    output logic                usr_bvalid,
    input  logic                usr_bready
);

    localparam int c_AXI_BYTES = AXI_DW / 8;
    localparam int c_SIZE      = $clog2(c_AXI_BYTES);
    localparam int c_OSTW      = $clog2(AMI_OD + 1);
    // Wide enough for the remaining count and the 4KB beat window.
    localparam int c_SW        = ((UBW > 13) ? UBW : 13) + 1;
    localparam logic [AXI_AW-1:0] c_LO_MASK = AXI_AW'(c_AXI_BYTES - 1);
    localparam logic [c_OSTW-1:0] c_OST_MAX = c_OSTW'(AMI_OD);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_run;
    logic [AXI_IW-1:0]   r_id;
    logic [AXI_AW-1:0]   r_addr;
    logic [UBW-1:0]      r_remaining;
    logic [c_OSTW-1:0]   r_ost;
    logic [AXI_LW-1:0]   r_beat;
    logic                r_ubvalid;
    logic [AXI_IW-1:0]   r_ubid;
    logic [1:0]          r_ubresp;
    logic                r_ublast;

    logic [c_SW-1:0]     w_rem;
    logic [c_SW-1:0]     w_bnd;
    logic [c_SW-1:0]     w_mb;
    logic [c_SW-1:0]     w_sub;
    logic                w_last_sub;
    logic                w_req_hs;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_len_full;
    logic                w_len_empty;
    logic [AXI_LW-1:0]   w_len_head;
    logic                w_trk_full;
    logic                w_trk_empty;
    logic                w_trk_last;
    logic                w_emit;
    logic [1:0]          w_emit_resp;

    // ---------------- sub-burst size ----------------
    assign w_rem = c_SW'(r_remaining);
    assign w_bnd = c_SW'((13'(BOUNDARY_4K) - {1'b0, r_addr[11:0]}) >> c_SIZE);
    assign w_mb  = c_SW'(MAX_BURST);

    always_comb begin
        w_sub = w_rem;
        if (w_mb  < w_sub) w_sub = w_mb;
        if (w_bnd < w_sub) w_sub = w_bnd;
    end

    assign w_last_sub = (w_rem == w_sub);

    // ---------------- AW FSM ----------------
    always_comb begin
        w_state_nxt = r_state;
        usr_awready = 1'b0;
        AWVALID     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A new ID waits for all bursts to drain so B stays in order.
                usr_awready = r_run && ((r_ost == '0) || (usr_awid == r_id));
                if (usr_awvalid && r_run && ((r_ost == '0) || (usr_awid == r_id)))
                    w_state_nxt = ST_SPLIT;
            end
            ST_SPLIT: begin
                AWVALID = (r_ost < c_OST_MAX) && !w_len_full && !w_trk_full;
                if (AWREADY && (r_ost < c_OST_MAX) && !w_len_full && !w_trk_full
                    && w_last_sub)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_req_hs = usr_awvalid && usr_awready;
    assign w_aw_hs  = AWVALID && AWREADY;
    assign w_w_hs   = WVALID && WREADY;
    assign w_b_hs   = BVALID && BREADY;

    assign AWID    = r_id;
    assign AWADDR  = r_addr;
    assign AWLEN   = AXI_LW'(w_sub - c_SW'(1));
    assign AWSIZE  = 3'(c_SIZE);
    assign AWBURST = BURST_INCR;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= ST_IDLE;
            r_run       <= 1'b0;
            r_id        <= '0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_ost       <= '0;
            r_beat      <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Holds usr_awready low until the first edge after reset.
            r_run   <= 1'b1;
            if (w_req_hs) begin
                r_id        <= usr_awid;
                r_addr      <= usr_awaddr & ~c_LO_MASK;
                r_remaining <= usr_awbeats;
            end else if (w_aw_hs) begin
                r_addr      <= r_addr + (AXI_AW'(w_sub) << c_SIZE);
                r_remaining <= r_remaining - UBW'(w_sub);
            end
            case ({w_aw_hs, w_b_hs})
                2'b10:   r_ost <= r_ost + c_OSTW'(1);
                2'b01:   r_ost <= r_ost - c_OSTW'(1);
                default: r_ost <= r_ost;
            endcase
            if (w_w_hs) r_beat <= WLAST ? '0 : r_beat + AXI_LW'(1);
        end
    end

    // ---------------- length / tracking FIFOs ----------------
    ami_sfifo #(
        .DW    (AXI_LW),
        .DEPTH (AMI_OD)
    ) u_len_fifo (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .push      (w_aw_hs),
        .push_data (AWLEN),
        .pop       (w_w_hs && WLAST),
        .pop_data  (w_len_head),
        .full      (w_len_full),
        .empty     (w_len_empty)
    );

    ami_sfifo #(
        .DW    (1),
        .DEPTH (AMI_OD)
    ) u_trk_fifo (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .push      (w_aw_hs),
        .push_data (w_last_sub),
        .pop       (w_b_hs),
        .pop_data  (w_trk_last),
        .full      (w_trk_full),
        .empty     (w_trk_empty)
    );

    // ---------------- W path ----------------
    // Beats only flow once their burst length is known, so W never leads AW.
    assign WVALID     = usr_wvalid && !w_len_empty;
    assign usr_wready = WREADY && !w_len_empty;
    assign WDATA      = usr_wdata;
    assign WSTRB      = usr_wstrb;
    assign WLAST      = !w_len_empty && (r_beat == w_len_head);

    // ---------------- B path ----------------
    assign BREADY = !w_trk_empty && (!r_ubvalid || usr_bready);

`ifdef AMI_W_RESP_MERGE_EN
    resp_t r_acc;
    resp_t w_merged;

    assign w_merged    = resp_worst(r_acc, resp_t'(BRESP));
    assign w_emit      = w_b_hs && w_trk_last;
    assign w_emit_resp = w_merged;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_acc <= OKAY;
        end else if (w_b_hs) begin
            r_acc <= w_trk_last ? OKAY : w_merged;
        end
    end
`else
    assign w_emit      = w_b_hs;
    assign w_emit_resp = BRESP;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_ubvalid <= 1'b0;
            r_ubid    <= '0;
            r_ubresp  <= '0;
            r_ublast  <= 1'b0;
        end else if (w_emit) begin
            r_ubvalid <= 1'b1;
            r_ubid    <= BID;
            r_ubresp  <= w_emit_resp;
            r_ublast  <= w_trk_last;
        end else if (usr_bready) begin
            r_ubvalid <= 1'b0;
        end
    end

    assign usr_bvalid = r_ubvalid;
    assign usr_bid    = r_ubid;
    assign usr_bresp  = r_ubresp;
    assign usr_blast  = r_ublast;

`ifndef SYNTHESIS
    a_beats_nonzero: assert property (@(posedge ACLK) disable iff (!ARESETn)
        (usr_awvalid && usr_awready) |-> (usr_awbeats != '0))
        else $error("usr_awbeats of zero accepted as a request");
`endif

endmodule
`default_nettype wire

// File: tb/tb_ami_w_split.sv
`default_nettype none
// ============================================================================
// Module   : tb_ami_w_split
// Purpose  : Directed self-checking bench for ami_w_split.
// Macros   : AMI_W_RESP_MERGE_EN selects the merged-response expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ami_w_split;

    localparam int DW = 128;
    localparam int AW = 32;
    localparam int IW = 8;
    localparam int LW = 8;
    localparam int UB = 16;

    logic            ACLK = 1'b0;
    logic            ARESETn;
    logic [IW-1:0]   AWID;
    logic [AW-1:0]   AWADDR;
    logic [LW-1:0]   AWLEN;
    logic [2:0]      AWSIZE;
    logic [1:0]      AWBURST;
    logic            AWVALID;
    logic            AWREADY;
    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WLAST;
    logic            WVALID;
    logic            WREADY;
    logic [IW-1:0]   BID;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [IW-1:0]   usr_awid;
    logic [AW-1:0]   usr_awaddr;
    logic [UB-1:0]   usr_awbeats;
    logic            usr_awvalid;
    logic            usr_awready;
    logic [DW-1:0]   usr_wdata;
    logic [DW/8-1:0] usr_wstrb;
    logic            usr_wvalid;
    logic            usr_wready;
    logic [IW-1:0]   usr_bid;
    logic [1:0]      usr_bresp;
    logic            usr_blast;
    logic            usr_bvalid;
    logic            usr_bready;

    int total = 0;
    int bad   = 0;
    int werr  = 0;
    int resp_tab [8];
    int aw_addr_q [$];
    int aw_len_q  [$];
    int wlast_q   [$];
    int ub_id_q   [$];
    int ub_resp_q [$];
    int ub_last_q [$];

    always #5 ACLK = ~ACLK;

    ami_w_split #(
        .AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW),
        .UBW(UB), .MAX_BURST(256), .AMI_OD(4)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .usr_awid(usr_awid), .usr_awaddr(usr_awaddr), .usr_awbeats(usr_awbeats),
        .usr_awvalid(usr_awvalid), .usr_awready(usr_awready),
        .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb), .usr_wvalid(usr_wvalid),
        .usr_wready(usr_wready),
        .usr_bid(usr_bid), .usr_bresp(usr_bresp), .usr_blast(usr_blast),
        .usr_bvalid(usr_bvalid), .usr_bready(usr_bready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_q();
        aw_addr_q.delete(); aw_len_q.delete(); wlast_q.delete();
        ub_id_q.delete(); ub_resp_q.delete(); ub_last_q.delete();
        werr = 0;
    endtask

    // Present one user request and hold it until accepted (bounded).
    task automatic req(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                       input logic [UB-1:0] beats);
        int n;
        n = 0;
        usr_awid = id; usr_awaddr = addr; usr_awbeats = beats; usr_awvalid = 1'b1;
        while (!usr_awready && n < 50) begin
            tick();
            n++;
        end
        chk("req accepted", usr_awready, 1'b1);
        tick();
        usr_awvalid = 1'b0;
    endtask

    // Free-running slave and data source until n_w beats and n_b B
    // responses are done; records every handshake for later checking.
    task automatic run(input int n_w, input int n_b, input logic [IW-1:0] id);
        int w_cnt;
        int b_cnt;
        int cyc;
        bit done;
        w_cnt = 0; b_cnt = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 6000) begin
            usr_wvalid = (w_cnt < n_w);
            usr_wdata  = {4{w_cnt}};
            usr_wstrb  = '1;
            BVALID     = (b_cnt < n_b);
            BRESP      = 2'(resp_tab[b_cnt % 8]);
            BID        = id;
            if (w_cnt == n_w && b_cnt == n_b && !usr_bvalid) begin
                done = 1'b1;
            end else begin
                @(negedge ACLK);
                if (AWVALID && AWREADY) begin
                    aw_addr_q.push_back(int'(AWADDR));
                    aw_len_q.push_back(int'(AWLEN));
                end
                if (WVALID && WREADY) begin
                    if (WDATA !== {4{w_cnt}}) werr++;
                    w_cnt++;
                    if (WLAST) wlast_q.push_back(w_cnt);
                end
                if (BVALID && BREADY) b_cnt++;
                if (usr_bvalid && usr_bready) begin
                    ub_id_q.push_back(int'(usr_bid));
                    ub_resp_q.push_back(int'(usr_bresp));
                    ub_last_q.push_back(int'(usr_blast));
                end
                tick();
                cyc++;
            end
        end
        chk("run w beats", 64'(w_cnt), 64'(n_w));
        chk("run b count", 64'(b_cnt), 64'(n_b));
        chk("run wdata", 64'(werr), 64'd0);
        BVALID = 1'b0;
        usr_wvalid = 1'b0;
    endtask

    initial begin
        int n_aw;
        ARESETn = 1'b0;
        AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b0; BRESP = 2'd0; BID = '0;
        usr_awid = '0; usr_awaddr = '0; usr_awbeats = '0; usr_awvalid = 1'b0;
        usr_wdata = '0; usr_wstrb = '1; usr_wvalid = 1'b0; usr_bready = 1'b1;
        resp_tab = '{default: 0};

        // ---- reset state ----
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst AWVALID", AWVALID, 1'b0);
        chk("rst WVALID", WVALID, 1'b0);
        chk("rst WLAST", WLAST, 1'b0);
        chk("rst BREADY", BREADY, 1'b0);
        chk("rst usr_bvalid", usr_bvalid, 1'b0);
        chk("rst usr_awready", usr_awready, 1'b0);
        ARESETn = 1'b1;
        tick();
        chk("post-rst usr_awready", usr_awready, 1'b1);

        // ---- 4KB crossing: 0x0FC0, 10 beats ----
        clear_q();
        req(8'd1, 32'h0FC0, 16'd10);
        chk("t1 AWSIZE", AWSIZE, 3'd4);
        chk("t1 AWBURST", AWBURST, 2'd1);
        run(10, 2, 8'd1);
        chk("t1 aw n", aw_addr_q.size(), 2);
        chk("t1 aw0 addr", aw_addr_q[0], 32'h0FC0);
        chk("t1 aw0 len", aw_len_q[0], 3);
        chk("t1 aw1 addr", aw_addr_q[1], 32'h1000);
        chk("t1 aw1 len", aw_len_q[1], 5);
        chk("t1 wlast n", wlast_q.size(), 2);
        chk("t1 wlast0", wlast_q[0], 4);
        chk("t1 wlast1", wlast_q[1], 10);
`ifdef AMI_W_RESP_MERGE_EN
        chk("t1 ub n", ub_resp_q.size(), 1);
        chk("t1 ub id", ub_id_q[0], 1);
        chk("t1 ub last", ub_last_q[0], 1);
`else
        chk("t1 ub n", ub_resp_q.size(), 2);
        chk("t1 ub0 last", ub_last_q[0], 0);
        chk("t1 ub1 last", ub_last_q[1], 1);
`endif

        // ---- MAX_BURST split: 0x0, 600 beats ----
        clear_q();
        req(8'd2, 32'h0, 16'd600);
        run(600, 3, 8'd2);
        chk("t2 aw n", aw_addr_q.size(), 3);
        chk("t2 aw0 len", aw_len_q[0], 255);
        chk("t2 aw1 addr", aw_addr_q[1], 32'h1000);
        chk("t2 aw1 len", aw_len_q[1], 255);
        chk("t2 aw2 addr", aw_addr_q[2], 32'h2000);
        chk("t2 aw2 len", aw_len_q[2], 87);
        chk("t2 wlast1", wlast_q[1], 512);
        chk("t2 wlast2", wlast_q[2], 600);
`ifdef AMI_W_RESP_MERGE_EN
        chk("t2 ub n", ub_resp_q.size(), 1);
        chk("t2 ub resp", ub_resp_q[0], 0);
`else
        chk("t2 ub n", ub_resp_q.size(), 3);
        chk("t2 ub2 resp", ub_resp_q[2], 0);
`endif

        // ---- response merge: OKAY, SLVERR, OKAY ----
        clear_q();
        resp_tab = '{0, 2, 0, 0, 0, 0, 0, 0};
        req(8'd4, 32'h0FF0, 16'd260);
        run(260, 3, 8'd4);
        chk("t3 aw0 len", aw_len_q[0], 0);
        chk("t3 aw2 len", aw_len_q[2], 2);
        chk("t3 wlast0", wlast_q[0], 1);
`ifdef AMI_W_RESP_MERGE_EN
        chk("t3 ub n", ub_resp_q.size(), 1);
        chk("t3 ub resp", ub_resp_q[0], 2);
        chk("t3 ub last", ub_last_q[0], 1);
        chk("t3 ub id", ub_id_q[0], 4);
`else
        chk("t3 ub n", ub_resp_q.size(), 3);
        chk("t3 ub0 resp", ub_resp_q[0], 0);
        chk("t3 ub1 resp", ub_resp_q[1], 2);
        chk("t3 ub2 resp", ub_resp_q[2], 0);
        chk("t3 ub0 last", ub_last_q[0], 0);
        chk("t3 ub1 last", ub_last_q[1], 0);
        chk("t3 ub2 last", ub_last_q[2], 1);
`endif
        resp_tab = '{default: 0};

        // ---- outstanding limit: 2000 beats, no B ----
        clear_q();
        req(8'd3, 32'h0, 16'd2000);
        n_aw = 0;
        repeat (12) begin
            @(negedge ACLK);
            if (AWVALID && AWREADY) n_aw++;
        end
        chk("t4 aw limit", 64'(n_aw), 64'd4);
        chk("t4 AWVALID held off", AWVALID, 1'b0);
        tick();
        run(2000, 8, 8'd3);
        chk("t4 aw rest n", aw_addr_q.size(), 4);
        chk("t4 aw rest0 addr", aw_addr_q[0], 32'h4000);
        chk("t4 aw last addr", aw_addr_q[3], 32'h7000);
        chk("t4 aw last len", aw_len_q[3], 207);
`ifdef AMI_W_RESP_MERGE_EN
        chk("t4 ub n", ub_resp_q.size(), 1);
`else
        chk("t4 ub n", ub_resp_q.size(), 8);
        chk("t4 ub7 last", ub_last_q[7], 1);
`endif

        // ---- ID-change drain and B backpressure ----
        req(8'd5, 32'h100, 16'd1);
        req(8'd5, 32'h200, 16'd1);
        tick();
        chk("t5 AWVALID idle", AWVALID, 1'b0);
        usr_awid = 8'd7;
        #1;
        chk("t5 id change blocked", usr_awready, 1'b0);
        usr_wvalid = 1'b1;
        usr_wdata = '0;
        chk("t5 w0 WLAST", WLAST, 1'b1);
        tick();
        chk("t5 w1 WLAST", WLAST, 1'b1);
        tick();
        usr_wvalid = 1'b0;
        chk("t5 WVALID no len", WVALID, 1'b0);
        usr_bready = 1'b0;
        BVALID = 1'b1; BRESP = 2'd2; BID = 8'd5;
        #1;
        chk("t5 BREADY first", BREADY, 1'b1);
        tick();
        chk("t5 ub valid", usr_bvalid, 1'b1);
        chk("t5 ub resp", usr_bresp, 2'd2);
        chk("t5 ub last", usr_blast, 1'b1);
        chk("t5 ub id", usr_bid, 8'd5);
        BRESP = 2'd3;
        #1;
        chk("t5 BREADY stalled", BREADY, 1'b0);
        tick();
        chk("t5 ub held resp", usr_bresp, 2'd2);
        chk("t5 still blocked", usr_awready, 1'b0);
        usr_bready = 1'b1;
        #1;
        chk("t5 BREADY resumed", BREADY, 1'b1);
        tick();
        BVALID = 1'b0;
        chk("t5 ub2 valid", usr_bvalid, 1'b1);
        chk("t5 ub2 resp", usr_bresp, 2'd3);
        chk("t5 drained ready", usr_awready, 1'b1);
        tick();
        chk("t5 ub consumed", usr_bvalid, 1'b0);

        // ---- reset mid-burst ----
        req(8'd6, 32'h0, 16'd8);
        tick();
        usr_wvalid = 1'b1;
        tick(); tick(); tick();
        chk("t6 mid WLAST", WLAST, 1'b0);
        ARESETn = 1'b0;
        #1;
        chk("t6 rst AWVALID", AWVALID, 1'b0);
        chk("t6 rst WVALID", WVALID, 1'b0);
        chk("t6 rst WLAST", WLAST, 1'b0);
        chk("t6 rst BREADY", BREADY, 1'b0);
        chk("t6 rst usr_bvalid", usr_bvalid, 1'b0);
        chk("t6 rst usr_awready", usr_awready, 1'b0);
        usr_wvalid = 1'b0;
        tick();
        ARESETn = 1'b1;
        tick();
        clear_q();
        req(8'd8, 32'h40, 16'd8);
        run(8, 1, 8'd8);
        chk("t6 aw addr", aw_addr_q[0], 32'h40);
        chk("t6 aw len", aw_len_q[0], 7);
        chk("t6 wlast", wlast_q[0], 8);
        chk("t6 ub n", ub_resp_q.size(), 1);
        chk("t6 ub last", ub_last_q[0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
